glitch_uart_tx: RTL and testbench
=================================

Name: glitch_uart_tx

Overview:
- UART transmitter on the return path of the glitch-test pipeline.
- Accepts 8-bit results and their data-valid strobe from the second pipeline stage.
- Buffers them in a small FIFO and serialises each byte as 8N1 to the host.
- Runs on the undivided board clock, not the glitched clock; the result/strobe pair is re-timed into clk_in1 upstream of this block.

Parameters:
- CLKS_PER_BIT, 868, clk_in1 cycles per UART bit (100 MHz / 115200); legal range >= 1.
- FIFO_DEPTH, 4, result bytes buffered; power of two, >= 2.

Ports:
- clk_in1  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- tx_data  in  8  result byte, sampled when DV_in = 1.
- DV_in  in  1  data-valid strobe; every high cycle is one push.
- tx_serial  out  1  UART line; idle high.
- tx_active  out  1  high while a frame is on the line (START/DATA/STOP).
- tx_done  out  1  one-cycle pulse at the end of each stop bit.
- overflow  out  1  sticky; set when a push is dropped; cleared only by reset.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst = 0, asynchronous):
  - tx_serial = 1, tx_active = 0, tx_done = 0, overflow = 0, fifo_count = 0.
  - FSM returns to IDLE and the FIFO is emptied.
  - Reset mid-frame aborts the frame at once; the line goes high with no stop bit.
- FIFO:
  - Push when DV_in = 1 and (count < FIFO_DEPTH, or a pop occurs in the same cycle).
  - Otherwise the byte is dropped and overflow is set.
  - Push and pop in the same cycle leave count unchanged.
  - Output order is FIFO order.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - tx_serial = 1, tx_active = 0.
    - If the FIFO is non-empty at a clock edge: pop, load the 8-bit shift register, go to START.
    - The pop happens on that same edge.
  - START:
    - tx_serial = 0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA:
    - tx_serial = shift[0] (LSB first); each bit is held CLKS_PER_BIT cycles.
    - Shift right after each bit.
    - After bit index 7, go to STOP.
  - STOP:
    - tx_serial = 1 for CLKS_PER_BIT cycles.
    - On the final edge, pulse tx_done for 1 cycle.
    - If the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- tx_active:
  - High in START, DATA and STOP.
  - Stays continuously high across back-to-back frames.
- Frame length: exactly 10 × CLKS_PER_BIT cycles, first start cycle to last stop cycle.
- Latency: first start-bit cycle begins 2 edges after a push into an empty FIFO with the FSM in IDLE (edge 1 writes, edge 2 pops).
- Bit counter: $clog2(CLKS_PER_BIT) bits (min 1); it resets to 0 on every bit boundary.
- Outputs are registered; tx_serial has no combinational path from the inputs.

Decomposition:
- Package glitch_uart_pkg holds:
  - enum tx_state_t {IDLE, START, DATA, STOP};
  - localparam DATA_W = 8;
  - localparam DEFAULT_CLKS_PER_BIT = 868.
- The receiver side of the same UART link reuses this package.
- Sub-module tx_fifo (parameter DEPTH, WIDTH):
  - ports: push, pop, wdata, rdata, count, full, empty;
  - async active-low reset;
  - read-data valid whenever empty = 0.
- The FSM and bit timer stay in glitch_uart_tx.

Test Plan:
- Single byte (CLKS_PER_BIT = 4): push 0xA5 → line levels 0,1,0,1,0,0,1,0,1,1 held 4 cycles each (40 cycles); tx_done pulses once on the last stop cycle; fifo_count returns to 0.
- Back-to-back: push 0x00, 0xFF, 0x3C on consecutive cycles → three contiguous 40-cycle frames with no idle gap; tx_active high for 120 cycles; 3 tx_done pulses; overflow = 0.
- Overflow (FIFO_DEPTH = 4): push 6 bytes on consecutive cycles into an empty idle block:
  - byte 1 popped on edge 2, bytes 2–5 buffered (count = 4), byte 6 dropped;
  - overflow = 1 and stays 1;
  - exactly 5 frames in order.
- Reset mid-frame: drop rst during DATA bit 3 with 2 bytes queued → tx_serial = 1 immediately, fifo_count = 0, tx_active = 0; release rst with no further pushes → line stays high indefinitely.
- CLKS_PER_BIT = 1: push 0x81 → 10-cycle frame 0,1,0,0,0,0,0,0,1,1; tx_done on cycle 10.
- Simultaneous push/pop when full: fill to 4 while busy, then push at the STOP→START edge → push accepted, count stays 4, overflow = 0.

Source files
------------

// File: rtl/glitch_uart_pkg.sv
// Shared types and constants for the glitch-test UART link (TX and RX sides).
package glitch_uart_pkg;

  localparam int unsigned DATA_W               = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/tx_fifo.sv
// Small power-of-two FIFO; rdata shows the head entry whenever empty is low.
module tx_fifo
  import glitch_uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/glitch_uart_tx.sv
// Buffered 8N1 UART transmitter for glitch-test results; runs on the board clock.
module glitch_uart_tx
  import glitch_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk_in1,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          DV_in,
  output logic                          tx_serial,
  output logic                          tx_active,
  output logic                          tx_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned       CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_serial_q, tx_serial_d;
  logic              tx_active_q, tx_active_d;
  logic              tx_done_q, tx_done_d;
  logic              overflow_q, overflow_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic              bit_end;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk_in1),
    .rst_n (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (tx_data),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_end   = (clk_cnt_q == CNT_MAX);
  // A full FIFO still accepts a byte on the edge the FSM pops one.
  assign fifo_push = DV_in && (!fifo_full || fifo_pop);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register on the same edge.
    tx_active_d = (state_d != IDLE);
    tx_done_d   = (state_d == STOP) && (clk_cnt_d == CNT_MAX);
    unique case (state_d)
      START:   tx_serial_d = 1'b0;
      DATA:    tx_serial_d = shift_d[0];
      default: tx_serial_d = 1'b1;
    endcase
    overflow_d = overflow_q || (DV_in && !fifo_push);
  end

  always_ff @(posedge clk_in1 or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      tx_serial_q <= 1'b1;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      tx_serial_q <= tx_serial_d;
      tx_active_q <= tx_active_d;
      tx_done_q   <= tx_done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign tx_serial = tx_serial_q;
  assign tx_active = tx_active_q;
  assign tx_done   = tx_done_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_glitch_uart_tx.sv
// Directed bench for glitch_uart_tx: one instance at 4 clks/bit, one at 1 clk/bit.
module tb_glitch_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d4, d1;
  logic       dv4, dv1;
  logic       ser4, act4, done4, ovf4;
  logic       ser1, act1, done1, ovf1;
  logic [2:0] cnt4, cnt1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  glitch_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut4 (
    .clk_in1 (clk), .rst (rst_n), .tx_data (d4), .DV_in (dv4),
    .tx_serial (ser4), .tx_active (act4), .tx_done (done4),
    .overflow (ovf4), .fifo_count (cnt4)
  );

  glitch_uart_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) dut1 (
    .clk_in1 (clk), .rst (rst_n), .tx_data (d1), .DV_in (dv1),
    .tx_serial (ser1), .tx_active (act1), .tx_done (done1),
    .overflow (ovf1), .fifo_count (cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic line(input int sel);
    return (sel != 0) ? ser1 : ser4;
  endfunction
  function automatic logic active(input int sel);
    return (sel != 0) ? act1 : act4;
  endfunction
  function automatic logic done(input int sel);
    return (sel != 0) ? done1 : done4;
  endfunction

  // Called just after a rising edge; the byte is sampled on the next edge.
  task automatic push(input int sel, input logic [7:0] b);
    if (sel != 0) begin d1 = b; dv1 = 1'b1; end
    else          begin d4 = b; dv4 = 1'b1; end
    @(posedge clk); #1;
    dv1 = 1'b0;
    dv4 = 1'b0;
  endtask

  // Checks the next 10*cpb cycles against an 8N1 frame of b.
  task automatic expect_frame(input int sel, input logic [7:0] b, input int cpb, input string name);
    for (int k = 0; k < 10*cpb; k++) begin
      int   j;
      logic lvl;
      j = k / cpb;
      if (j == 0)      lvl = 1'b0;
      else if (j == 9) lvl = 1'b1;
      else             lvl = b[j-1];
      @(negedge clk);
      check($sformatf("%s serial c%0d", name, k), line(sel), lvl);
      check($sformatf("%s active c%0d", name, k), active(sel), 1'b1);
      check($sformatf("%s done c%0d", name, k), done(sel), (k == 10*cpb-1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bad;
    rst_n = 1'b0; dv4 = 1'b0; dv1 = 1'b0; d4 = '0; d1 = '0;
    repeat (2) @(negedge clk);
    check("rst serial", ser4, 1'b1);
    check("rst active", act4, 1'b0);
    check("rst done",   done4, 1'b0);
    check("rst ovf",    ovf4, 1'b0);
    check("rst count",  cnt4, 3'd0);
    check("rst serial1", ser1, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single byte, 4 clks/bit
    push(0, 8'hA5);
    @(negedge clk);
    check("single latency idle", ser4, 1'b1);
    check("single count1", cnt4, 3'd1);
    expect_frame(0, 8'hA5, 4, "single");
    @(negedge clk);
    check("single after serial", ser4, 1'b1);
    check("single after active", act4, 1'b0);
    check("single after count",  cnt4, 3'd0);
    check("single after done",   done4, 1'b0);
    @(posedge clk); #1;

    // 1 clk/bit
    push(1, 8'h81);
    @(negedge clk);
    check("cpb1 latency idle", ser1, 1'b1);
    expect_frame(1, 8'h81, 1, "cpb1");
    @(negedge clk);
    check("cpb1 after serial", ser1, 1'b1);
    check("cpb1 after active", act1, 1'b0);
    check("cpb1 after count",  cnt1, 3'd0);
    @(posedge clk); #1;

    // Back-to-back frames
    fork
      begin push(0, 8'h00); push(0, 8'hFF); push(0, 8'h3C); end
      begin
        repeat (2) @(negedge clk);
        expect_frame(0, 8'h00, 4, "b2b0");
        expect_frame(0, 8'hFF, 4, "b2b1");
        expect_frame(0, 8'h3C, 4, "b2b2");
      end
    join
    @(negedge clk);
    check("b2b after active", act4, 1'b0);
    check("b2b ovf",          ovf4, 1'b0);
    check("b2b count",        cnt4, 3'd0);
    @(posedge clk); #1;

    // Full FIFO with push on the STOP->START pop edge
    fork
      begin
        push(0, 8'h11);
        repeat (3) @(posedge clk); #1;
        push(0, 8'h21); push(0, 8'h22); push(0, 8'h23); push(0, 8'h24);
        check("simul full count", cnt4, 3'd4);
        repeat (33) @(posedge clk); #1;
        check("simul pre count", cnt4, 3'd4);
        check("simul pre ovf",   ovf4, 1'b0);
        push(0, 8'h5A);
        check("simul post count", cnt4, 3'd4);
        check("simul post ovf",   ovf4, 1'b0);
      end
      begin
        repeat (2) @(negedge clk);
        expect_frame(0, 8'h11, 4, "simulA");
        expect_frame(0, 8'h21, 4, "simulB1");
        expect_frame(0, 8'h22, 4, "simulB2");
        expect_frame(0, 8'h23, 4, "simulB3");
        expect_frame(0, 8'h24, 4, "simulB4");
        expect_frame(0, 8'h5A, 4, "simulF");
      end
    join
    @(negedge clk);
    check("simul after active", act4, 1'b0);
    check("simul after count",  cnt4, 3'd0);
    check("simul after ovf",    ovf4, 1'b0);
    @(posedge clk); #1;

    // Overflow: six consecutive pushes, sixth dropped
    fork
      begin
        push(0, 8'h31); push(0, 8'h32); push(0, 8'h33);
        push(0, 8'h34); push(0, 8'h35); push(0, 8'h36);
        @(negedge clk);
        check("ovf count", cnt4, 3'd4);
        check("ovf flag",  ovf4, 1'b1);
      end
      begin
        repeat (2) @(negedge clk);
        expect_frame(0, 8'h31, 4, "ovf1");
        expect_frame(0, 8'h32, 4, "ovf2");
        expect_frame(0, 8'h33, 4, "ovf3");
        expect_frame(0, 8'h34, 4, "ovf4");
        expect_frame(0, 8'h35, 4, "ovf5");
      end
    join
    @(negedge clk);
    check("ovf sticky",        ovf4, 1'b1);
    check("ovf after count",   cnt4, 3'd0);
    check("ovf after active",  act4, 1'b0);
    check("ovf after serial",  ser4, 1'b1);
    @(posedge clk); #1;

    // Reset during DATA bit 3 with two bytes queued
    push(0, 8'h00); push(0, 8'h77); push(0, 8'h88);
    repeat (16) @(posedge clk); #2;
    check("rstmid pre serial", ser4, 1'b0);
    check("rstmid pre active", act4, 1'b1);
    check("rstmid pre count",  cnt4, 3'd2);
    rst_n = 1'b0;
    #1;
    check("rstmid serial", ser4, 1'b1);
    check("rstmid count",  cnt4, 3'd0);
    check("rstmid active", act4, 1'b0);
    check("rstmid done",   done4, 1'b0);
    check("rstmid ovf",    ovf4, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (ser4 !== 1'b1 || act4 !== 1'b0) bad++;
    end
    check("rstmid stays idle", bad, 0);
    check("rstmid final count", cnt4, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
